// File: rtl/color_pkg.sv
// Shared definitions for the RGB colour sequencer: colour codes, index and FSM enums,
// and the index-to-colour map used to drive the LED pins.
package color_pkg;

    typedef logic [2:0] rgb_t;  // {R,G,B}, 1 = channel on

    localparam rgb_t RGB_OFF     = 3'b000;
    localparam rgb_t RGB_RED     = 3'b100;
    localparam rgb_t RGB_GREEN   = 3'b010;
    localparam rgb_t RGB_BLUE    = 3'b001;
    localparam rgb_t RGB_YELLOW  = 3'b110;
    localparam rgb_t RGB_CYAN    = 3'b011;
    localparam rgb_t RGB_MAGENTA = 3'b101;
    localparam rgb_t RGB_WHITE   = 3'b111;

    typedef enum logic [2:0] {
        IDX_OFF     = 3'd0,
        IDX_RED     = 3'd1,
        IDX_GREEN   = 3'd2,
        IDX_BLUE    = 3'd3,
        IDX_YELLOW  = 3'd4,
        IDX_CYAN    = 3'd5,
        IDX_MAGENTA = 3'd6,
        IDX_WHITE   = 3'd7
    } color_idx_e;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } seq_state_e;

    function automatic rgb_t idx_to_rgb(input logic [2:0] idx);
        rgb_t rgb;
        rgb = RGB_OFF;
        case (color_idx_e'(idx))
            IDX_OFF:     rgb = RGB_OFF;
            IDX_RED:     rgb = RGB_RED;
            IDX_GREEN:   rgb = RGB_GREEN;
            IDX_BLUE:    rgb = RGB_BLUE;
            IDX_YELLOW:  rgb = RGB_YELLOW;
            IDX_CYAN:    rgb = RGB_CYAN;
            IDX_MAGENTA: rgb = RGB_MAGENTA;
            IDX_WHITE:   rgb = RGB_WHITE;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/color_pwm.sv
// Brightness PWM for the LED path: free-running counter compared against a duty code
// that is only reloaded at the period boundary, so a duty change never glitches mid-period.
module color_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic                pwm_on_o
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] bright_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (pwm_cnt_q == '1) begin
                bright_q <= brightness_i;
            end
        end
    end

    assign pwm_on_o = (pwm_cnt_q < bright_q);

endmodule

// File: rtl/color_sequencer.sv
// RGB LED colour sequencer: button/dwell-timer stepping of a colour index, mapped to
// active-low R/G/B pins. Define COLOR_SEQ_PWM_EN to add PWM brightness dimming.
module color_sequencer
    import color_pkg::*;
#(
    parameter int NUM_STATES   = 8,
    parameter int DWELL_CYCLES = 6_000_000,
    parameter int PWM_BITS     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    input  logic                auto_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic                rLed,
    output logic                gLed,
    output logic                bLed,
    output logic [2:0]          state_o
);

    localparam int                 DWELL_W    = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]         IDX_LAST   = 3'(NUM_STATES - 1);

    logic               step_q;
    logic               step_p;
    logic [2:0]         index_q, index_d;
    logic [2:0]         index_inc;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               dwell_term;
    seq_state_e         fsm_q, fsm_d;
    logic [2:0]         state_q;
    logic [2:0]         led_q;
    logic [2:0]         chan_en;

    assign step_p     = step_i & ~step_q;
    assign dwell_term = (dwell_q == DWELL_LAST);
    assign index_inc  = (index_q == IDX_LAST) ? 3'd0 : index_q + 3'd1;

    // A button edge and a dwell expiry in the same cycle advance the index only once.
    always_comb begin
        index_d = index_q;
        dwell_d = dwell_q;
        fsm_d   = fsm_q;
        case (fsm_q)
            MANUAL: begin
                if (step_p) begin
                    index_d = index_inc;
                end
                if (auto_i) begin
                    fsm_d   = AUTO;
                    dwell_d = '0;
                end
            end
            AUTO: begin
                if (!auto_i) begin
                    fsm_d   = MANUAL;
                    dwell_d = '0;
                end else if (step_p || dwell_term) begin
                    index_d = index_inc;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: begin
                fsm_d   = MANUAL;
                dwell_d = '0;
            end
        endcase
    end

`ifdef COLOR_SEQ_PWM_EN
    logic pwm_on;

    color_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm (
        .clk         (clk),
        .rst         (rst),
        .brightness_i(brightness_i),
        .pwm_on_o    (pwm_on)
    );

    assign chan_en = {3{pwm_on}};
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness_i;
    assign chan_en           = 3'b111;
`endif

    // step_q resets high so a button held through reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= 1'b1;
            index_q <= IDX_OFF;
            dwell_q <= '0;
            fsm_q   <= MANUAL;
            state_q <= 3'd0;
            led_q   <= 3'b111;
        end else begin
            step_q  <= step_i;
            index_q <= index_d;
            dwell_q <= dwell_d;
            fsm_q   <= fsm_d;
            state_q <= index_q;
            led_q   <= ~(idx_to_rgb(index_q) & chan_en);
        end
    end

    assign rLed    = led_q[2];
    assign gLed    = led_q[1];
    assign bLed    = led_q[0];
    assign state_o = state_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Directed scoreboard bench for color_sequencer (DWELL_CYCLES=10); a second instance covers
// NUM_STATES=4, and the brightness steps run when COLOR_SEQ_PWM_EN is defined.
module tb_color_sequencer;

    localparam logic [2:0] PINS [8] = '{3'b111, 3'b011, 3'b101, 3'b110,
                                        3'b001, 3'b100, 3'b010, 3'b000};

    logic       clk = 1'b0;
    logic       rst;
    logic       step_i, auto_i;
    logic [3:0] brightness_i;
    logic       rLed, gLed, bLed;
    logic [2:0] state_o;
    logic       step4_i, auto4_i;
    logic       r4, g4, b4;
    logic [2:0] state4_o;

    typedef struct {
        logic [2:0]  st;
        int unsigned due;
    } exp_t;

    exp_t        exp_q [$];
    int unsigned cyc = 0;
    logic [2:0]  prev_st = 3'd0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    color_sequencer #(.NUM_STATES(8), .DWELL_CYCLES(10), .PWM_BITS(4)) dut (
        .clk(clk), .rst(rst), .step_i(step_i), .auto_i(auto_i), .brightness_i(brightness_i),
        .rLed(rLed), .gLed(gLed), .bLed(bLed), .state_o(state_o)
    );

    color_sequencer #(.NUM_STATES(4), .DWELL_CYCLES(10), .PWM_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .step_i(step4_i), .auto_i(auto4_i), .brightness_i(4'd15),
        .rLed(r4), .gLed(g4), .bLed(b4), .state_o(state4_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and retire scoreboard entries on state_o changes.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            prev_st = state_o;
        end else if (state_o !== prev_st) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_change", 32'(state_o), 32'(prev_st));
            end else begin
                e = exp_q.pop_front();
                check("sb_state", 32'(state_o), 32'(e.st));
                check("sb_cycle", cyc, e.due);
`ifndef COLOR_SEQ_PWM_EN
                check("sb_pins", 32'({rLed, gLed, bLed}), 32'(PINS[e.st]));
`endif
                $display("t=%0t cyc=%0d state_o=%0d pins=%b%b%b", $time, cyc, state_o, rLed, gLed, bLed);
            end
            prev_st = state_o;
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            e = exp_q.pop_front();
            check("sb_late", cyc, e.due);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [2:0] st, input int unsigned due);
        exp_t e;
        e.st  = st;
        e.due = due;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [2:0]  idx;
        logic [2:0]  idx4;
        int unsigned c0;
`ifdef COLOR_SEQ_PWM_EN
        logic        prev_r;
        logic        found;
        int          nr, ng, nb;
`endif
        rst = 1'b1; step_i = 1'b1; auto_i = 1'b0; brightness_i = 4'd0;
        step4_i = 1'b0; auto4_i = 1'b0;

        // Reset with the button held through release: no advance.
        ticks(3);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_pins", 32'({rLed, gLed, bLed}), 32'h7);
        rst = 1'b0;
        ticks(4);
        check("held_no_advance", 32'(state_o), 32'd0);
        step_i = 1'b0;
        ticks(3);

        // Manual stepping with wrap 7 -> 0.
        idx = 3'd0;
        for (int k = 1; k <= 9; k++) begin
            step_i = 1'b1;
            idx    = (idx == 3'd7) ? 3'd0 : idx + 3'd1;
            push(idx, cyc + 2);
            if (k == 1) begin
                tick();
                check("pin_not_early_state", 32'(state_o), 32'd0);
                check("pin_not_early", 32'({rLed, gLed, bLed}), 32'h7);
                tick();
                check("pin_two_clk_state", 32'(state_o), 32'd1);
                check("pin_two_clk_red", 32'({rLed, gLed, bLed}), 32'h3);
                tick();
            end else begin
                ticks(3);
            end
            step_i = 1'b0;
            ticks(3);
        end
        check("manual_final", 32'(state_o), 32'd1);
        check("manual_sb_empty", exp_q.size(), 32'd0);

        // Auto advance every 10 clk from index 0.
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
        c0 = cyc;
        auto_i = 1'b1;
        for (int k = 1; k <= 8; k++) push(3'(k % 8), c0 + 2 + 10 * k);
        while (cyc < c0 + 90) tick();
        check("auto_wrapped", 32'(state_o), 32'd0);

        // Button edge lands on the terminal-count cycle: single advance, dwell restarts.
        step_i = 1'b1;
        push(3'd1, c0 + 92);
        push(3'd2, c0 + 102);
        ticks(3);
        step_i = 1'b0;
        while (cyc < c0 + 105) tick();
        check("collide_state", 32'(state_o), 32'd2);
        auto_i = 1'b0;
        ticks(50);
        check("frozen_state", 32'(state_o), 32'd2);
        check("auto_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset mid-dwell in AUTO.
        auto_i = 1'b1;
        ticks(5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_pins", 32'({rLed, gLed, bLed}), 32'h7);
        ticks(2);
        auto_i = 1'b0;
        rst = 1'b0;
        ticks(2);

        // NUM_STATES=4 instance.
        idx4 = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            step4_i = 1'b1;
            ticks(3);
            step4_i = 1'b0;
            ticks(3);
            idx4 = (idx4 == 3'd3) ? 3'd0 : idx4 + 3'd1;
            check("n4_state", 32'(state4_o), 32'(idx4));
            check("n4_in_range", 32'(state4_o <= 3'd3), 32'd1);
`ifndef COLOR_SEQ_PWM_EN
            check("n4_pins", 32'({r4, g4, b4}), 32'(PINS[idx4]));
`endif
            $display("t=%0t n4 step %0d state_o=%0d", $time, k, state4_o);
        end

`ifdef COLOR_SEQ_PWM_EN
        // Step main index to white, then measure duty per 16-clk period.
        idx = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            step_i = 1'b1;
            idx    = idx + 3'd1;
            push(idx, cyc + 2);
            ticks(3);
            step_i = 1'b0;
            ticks(3);
        end
        check("pwm_index", 32'(state_o), 32'd7);
        brightness_i = 4'd4;
        ticks(40);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_r = rLed;
            tick();
            if (prev_r && !rLed) found = 1'b1;
        end
        check("pwm_sync", 32'(found), 32'd1);
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            if (i == 2) brightness_i = 4'd12;
            nr += int'(!rLed); ng += int'(!gLed); nb += int'(!bLed);
        end
        check("pwm4_r", nr, 4); check("pwm4_g", ng, 4); check("pwm4_b", nb, 4);
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            nr += int'(!rLed); ng += int'(!gLed); nb += int'(!bLed);
        end
        check("pwm12_r", nr, 12); check("pwm12_g", ng, 12); check("pwm12_b", nb, 12);
        brightness_i = 4'd0;
        ticks(40);
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            nr += int'(!rLed); ng += int'(!gLed); nb += int'(!bLed);
        end
        check("pwm0_r", nr, 0); check("pwm0_g", ng, 0); check("pwm0_b", nb, 0);
        check("pwm_sb_empty", exp_q.size(), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
